// File: rtl/meas_pkg.sv
// Shared types and defaults for the measurement readout path.
package meas_pkg;

  localparam int MEAS_DATA_W     = 24;
  localparam int MEAS_FIFO_DEPTH = 16;
  localparam int MEAS_RD_LAT     = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SERVE
  } meas_state_e;

  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/meas_readout_ctrl_if.sv
// FIFO-side and command-side signals of the measurement readout controller.
interface meas_readout_ctrl_if import meas_pkg::*; #(
  parameter int DATA_W = MEAS_DATA_W,
  parameter int DEPTH  = MEAS_FIFO_DEPTH
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] fifo_q;
  logic              fifo_wr_en;
  logic              ext_rd_en;
  logic              fifo_rd_en;
  logic              byte_req;
  logic              spi_cs;
  logic              xfer_done;
  logic              err_clr;
  logic [7:0]        meas_data;
  logic              meas_valid;
  logic [LVL_W-1:0]  fifo_level;
  logic              underflow;
  logic              req_busy;

  modport slave (
    input  fifo_q, fifo_wr_en, ext_rd_en, byte_req, spi_cs, xfer_done, err_clr,
    output fifo_rd_en, meas_data, meas_valid, fifo_level, underflow, req_busy
  );

  modport master (
    output fifo_q, fifo_wr_en, ext_rd_en, byte_req, spi_cs, xfer_done, err_clr,
    input  fifo_rd_en, meas_data, meas_valid, fifo_level, underflow, req_busy
  );

endinterface

// File: rtl/level_counter.sv
// Saturating up/down occupancy counter; a simultaneous inc and dec cancel.
module level_counter #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_12mhz,
  input  logic             rst_sync,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [LVL_W-1:0] level_o
);

  logic [LVL_W-1:0] level_q, level_d;
  logic             inc_ok, dec_ok;

  always_comb begin
    inc_ok  = inc_i && (level_q < LVL_W'(DEPTH));
    dec_ok  = dec_i && (level_q != '0);
    level_d = level_q;
    if (inc_ok && !dec_ok) begin
      level_d = level_q + LVL_W'(1);
    end else if (dec_ok && !inc_ok) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk_12mhz or posedge rst_sync) begin
    if (rst_sync) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/meas_readout_ctrl.sv
// Pops one count word per SPI read and serialises it byte by byte to main_ctrl.
//   state    | meaning
//   ST_IDLE  | no word held; byte_req starts a FIFO pop or flags underflow
//   ST_FETCH | pop issued, waiting RD_LAT cycles for fifo_q
//   ST_SERVE | word latched; each byte_req advances to the next byte
module meas_readout_ctrl import meas_pkg::*; #(
  parameter int         DATA_W     = MEAS_DATA_W,
  parameter int         DEPTH      = MEAS_FIFO_DEPTH,
  parameter int         RD_LAT     = MEAS_RD_LAT,
  parameter int         MSB_FIRST  = 0,
  parameter logic [7:0] EMPTY_BYTE = 8'hFF
) (
  input logic                clk_12mhz,
  input logic                rst_sync,
  meas_readout_ctrl_if.slave bus
);

  localparam int BYTES = bytes_of(DATA_W);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int LAT_W = 3;

  meas_state_e       state_q, state_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [7:0]        meas_data_q, meas_data_d;
  logic              meas_valid_q, meas_valid_d;
  logic              fifo_rd_en_q, fifo_rd_en_d;
  logic              underflow_q, underflow_d;
  logic              req_busy_q, req_busy_d;
  logic              cs_meta_q, cs_sync_q, cs_dly_q;
  logic              cs_rise, abort;
  logic              uf_set, rb_set;
  logic [LVL_W-1:0]  level;

  function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] w,
                                           input logic [IDX_W-1:0]  k);
    int                pos;
    logic [DATA_W-1:0] shifted;
    pos     = (MSB_FIRST != 0) ? (BYTES - 1 - int'(k)) : int'(k);
    shifted = w >> (8 * pos);
    return shifted[7:0];
  endfunction

  // cs idles high, so the synchroniser resets to 1 to avoid a spurious rise.
  always_ff @(posedge clk_12mhz or posedge rst_sync) begin
    if (rst_sync) begin
      cs_meta_q <= 1'b1;
      cs_sync_q <= 1'b1;
      cs_dly_q  <= 1'b1;
    end else begin
      cs_meta_q <= bus.spi_cs;
      cs_sync_q <= cs_meta_q;
      cs_dly_q  <= cs_sync_q;
    end
  end

  assign cs_rise = cs_sync_q & ~cs_dly_q;
  assign abort   = cs_rise | bus.xfer_done;

  level_counter #(.DEPTH(DEPTH)) u_level (
    .clk_12mhz (clk_12mhz),
    .rst_sync  (rst_sync),
    .inc_i     (bus.fifo_wr_en),
    .dec_i     (fifo_rd_en_q | bus.ext_rd_en),
    .level_o   (level)
  );

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    lat_cnt_d    = lat_cnt_q;
    word_d       = word_q;
    meas_data_d  = meas_data_q;
    meas_valid_d = meas_valid_q;
    fifo_rd_en_d = 1'b0;
    uf_set       = 1'b0;
    rb_set       = 1'b0;

    // An abort drops any held or in-flight word; a pop already issued stays counted.
    if (abort) begin
      state_d      = ST_IDLE;
      meas_valid_d = 1'b0;
      byte_idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.byte_req) begin
            if (level != '0) begin
              fifo_rd_en_d = 1'b1;
              lat_cnt_d    = '0;
              state_d      = ST_FETCH;
            end else begin
              meas_data_d = EMPTY_BYTE;
              uf_set      = 1'b1;
            end
          end
        end
        ST_FETCH: begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
          if (bus.byte_req) begin
            rb_set = 1'b1;
          end
          if (lat_cnt_q == LAT_W'(RD_LAT - 1)) begin
            word_d       = bus.fifo_q;
            meas_data_d  = pick_byte(bus.fifo_q, IDX_W'(0));
            meas_valid_d = 1'b1;
            byte_idx_d   = '0;
            state_d      = ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (bus.byte_req) begin
            if (byte_idx_q == IDX_W'(BYTES - 1)) begin
              meas_valid_d = 1'b0;
              byte_idx_d   = '0;
              state_d      = ST_IDLE;
            end else begin
              byte_idx_d  = byte_idx_q + IDX_W'(1);
              meas_data_d = pick_byte(word_q, byte_idx_q + IDX_W'(1));
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    underflow_d = uf_set | (underflow_q & ~bus.err_clr);
    req_busy_d  = rb_set | (req_busy_q & ~bus.err_clr);
  end

  always_ff @(posedge clk_12mhz or posedge rst_sync) begin
    if (rst_sync) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= '0;
      lat_cnt_q    <= '0;
      word_q       <= '0;
      meas_data_q  <= 8'h00;
      meas_valid_q <= 1'b0;
      fifo_rd_en_q <= 1'b0;
      underflow_q  <= 1'b0;
      req_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      lat_cnt_q    <= lat_cnt_d;
      word_q       <= word_d;
      meas_data_q  <= meas_data_d;
      meas_valid_q <= meas_valid_d;
      fifo_rd_en_q <= fifo_rd_en_d;
      underflow_q  <= underflow_d;
      req_busy_q   <= req_busy_d;
    end
  end

  assign bus.fifo_rd_en = fifo_rd_en_q;
  assign bus.meas_data  = meas_data_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.fifo_level = level;
  assign bus.underflow  = underflow_q;
  assign bus.req_busy   = req_busy_q;

endmodule

// File: tb/tb_meas_readout_ctrl.sv
// Directed bench: default 24-bit LSB-first instance plus a 32-bit MSB-first, RD_LAT=3 instance.
module tb_meas_readout_ctrl;

  logic clk_12mhz = 1'b0;
  logic rst_sync  = 1'b1;
  always #5 clk_12mhz = ~clk_12mhz;

  meas_readout_ctrl_if #(.DATA_W(24), .DEPTH(16)) bus0 ();
  meas_readout_ctrl_if #(.DATA_W(32), .DEPTH(16)) bus1 ();

  meas_readout_ctrl #(
    .DATA_W(24), .DEPTH(16), .RD_LAT(2), .MSB_FIRST(0), .EMPTY_BYTE(8'hFF)
  ) u_dut (
    .clk_12mhz (clk_12mhz),
    .rst_sync  (rst_sync),
    .bus       (bus0)
  );

  meas_readout_ctrl #(
    .DATA_W(32), .DEPTH(16), .RD_LAT(3), .MSB_FIRST(1), .EMPTY_BYTE(8'hFF)
  ) u_dut32 (
    .clk_12mhz (clk_12mhz),
    .rst_sync  (rst_sync),
    .bus       (bus1)
  );

  // FIFO model: fifo_q carries the head word only in the cycle the controller
  // should sample it (RD_LAT-1 cycles after the strobe cycle), junk otherwise.
  logic [23:0] word0 = 24'h0;
  logic [31:0] word1 = 32'h0;
  logic [7:0]  hist0 = 8'h0;
  logic [7:0]  hist1 = 8'h0;
  int          rd_cnt0 = 0;

  always @(posedge clk_12mhz) begin
    hist0 <= {hist0[6:0], bus0.fifo_rd_en};
    hist1 <= {hist1[6:0], bus1.fifo_rd_en};
    if (bus0.fifo_rd_en) rd_cnt0 <= rd_cnt0 + 1;
  end

  assign bus0.fifo_q = hist0[0] ? word0 : ~word0;
  assign bus1.fifo_q = hist1[1] ? word1 : ~word1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       req, wr, ext, clr, done;
    logic [7:0] e_data;
    logic       e_valid;
    logic [4:0] e_lvl;
    logic       e_uf, e_rb, e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic req, input logic wr, input logic ext, input logic clr,
                     input logic done, input logic [7:0] d, input logic v, input int l,
                     input logic uf, input logic rb, input logic rd);
    vec_t x;
    x.req = req; x.wr = wr; x.ext = ext; x.clr = clr; x.done = done;
    x.e_data = d; x.e_valid = v; x.e_lvl = 5'(l);
    x.e_uf = uf; x.e_rb = rb; x.e_rd = rd;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_12mhz);
    #1;
  endtask

  task automatic pulse_req(input bit sel);
    if (sel) bus1.byte_req = 1'b1; else bus0.byte_req = 1'b1;
    tick();
    bus0.byte_req = 1'b0;
    bus1.byte_req = 1'b0;
  endtask

  task automatic req_and_wait(input bit sel, output int lat);
    pulse_req(sel);
    lat = 1;
    while (((sel ? bus1.meas_valid : bus0.meas_valid) == 1'b0) && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int rd_mark;
    logic [7:0] exp32 [4];
    exp32[0] = 8'h11; exp32[1] = 8'h22; exp32[2] = 8'h33; exp32[3] = 8'h44;

    bus0.fifo_wr_en = 0; bus0.ext_rd_en = 0; bus0.byte_req = 0;
    bus0.spi_cs = 1; bus0.xfer_done = 0; bus0.err_clr = 0;
    bus1.fifo_wr_en = 0; bus1.ext_rd_en = 0; bus1.byte_req = 0;
    bus1.spi_cs = 1; bus1.xfer_done = 0; bus1.err_clr = 0;
    word0 = 24'hA1B2C3;
    rst_sync = 1'b1;
    tick(); tick();
    rst_sync = 1'b0;

    // req wr ext clr done | data valid level uf rb rd
    add(0,0,0,0,0, 8'h00,0,0, 0,0,0);
    add(1,0,0,0,0, 8'hFF,0,0, 1,0,0);
    add(0,0,0,0,0, 8'hFF,0,0, 1,0,0);
    add(1,0,0,1,0, 8'hFF,0,0, 1,0,0);
    add(0,0,0,1,0, 8'hFF,0,0, 0,0,0);
    add(0,0,1,0,0, 8'hFF,0,0, 0,0,0);
    add(0,1,0,0,0, 8'hFF,0,1, 0,0,0);
    add(0,1,0,0,0, 8'hFF,0,2, 0,0,0);
    add(0,1,0,0,0, 8'hFF,0,3, 0,0,0);
    add(1,0,0,0,0, 8'hFF,0,3, 0,0,1);
    add(0,0,0,0,0, 8'hFF,0,2, 0,0,0);
    add(0,0,0,0,0, 8'hC3,1,2, 0,0,0);
    repeat (5) add(0,0,0,0,0, 8'hC3,1,2, 0,0,0);
    add(1,0,0,0,0, 8'hB2,1,2, 0,0,0);
    repeat (7) add(0,0,0,0,0, 8'hB2,1,2, 0,0,0);
    add(1,0,0,0,0, 8'hA1,1,2, 0,0,0);
    repeat (7) add(0,0,0,0,0, 8'hA1,1,2, 0,0,0);
    add(1,0,0,0,0, 8'hA1,0,2, 0,0,0);
    add(0,0,0,0,0, 8'hA1,0,2, 0,0,0);
    add(0,1,0,0,0, 8'hA1,0,3, 0,0,0);
    add(0,1,0,0,0, 8'hA1,0,4, 0,0,0);
    add(0,1,0,0,0, 8'hA1,0,5, 0,0,0);
    add(1,0,0,0,0, 8'hA1,0,5, 0,0,1);
    add(0,1,0,0,0, 8'hA1,0,5, 0,0,0);
    add(1,0,0,0,0, 8'hC3,1,5, 0,1,0);
    add(0,0,0,0,0, 8'hC3,1,5, 0,1,0);
    add(0,0,0,1,0, 8'hC3,1,5, 0,0,0);
    add(0,0,0,0,1, 8'hC3,0,5, 0,0,0);
    add(1,0,0,0,1, 8'hC3,0,5, 0,0,0);
    add(0,0,0,0,0, 8'hC3,0,5, 0,0,0);
    for (int l = 6; l <= 16; l++) add(0,1,0,0,0, 8'hC3,0,l, 0,0,0);
    add(0,1,0,0,0, 8'hC3,0,16, 0,0,0);
    add(0,0,1,0,0, 8'hC3,0,15, 0,0,0);
    add(0,1,1,0,0, 8'hC3,0,15, 0,0,0);

    foreach (vecs[i]) begin
      bus0.byte_req   = vecs[i].req;
      bus0.fifo_wr_en = vecs[i].wr;
      bus0.ext_rd_en  = vecs[i].ext;
      bus0.err_clr    = vecs[i].clr;
      bus0.xfer_done  = vecs[i].done;
      tick();
      chk($sformatf("v%0d meas_data", i),  bus0.meas_data,  vecs[i].e_data);
      chk($sformatf("v%0d meas_valid", i), bus0.meas_valid, vecs[i].e_valid);
      chk($sformatf("v%0d fifo_level", i), bus0.fifo_level, vecs[i].e_lvl);
      chk($sformatf("v%0d underflow", i),  bus0.underflow,  vecs[i].e_uf);
      chk($sformatf("v%0d req_busy", i),   bus0.req_busy,   vecs[i].e_rb);
      chk($sformatf("v%0d fifo_rd_en", i), bus0.fifo_rd_en, vecs[i].e_rd);
    end
    bus0.byte_req = 0; bus0.fifo_wr_en = 0; bus0.ext_rd_en = 0;
    bus0.err_clr = 0; bus0.xfer_done = 0;

    // chip-select rise while serving abandons the word
    bus0.spi_cs = 1'b0;
    tick(); tick(); tick();
    word0 = 24'h0A0B0C;
    req_and_wait(0, lat);
    chk("cs seq latency", 64'(lat), 64'd3);
    chk("cs seq byte0", bus0.meas_data, 8'h0C);
    pulse_req(0);
    chk("cs seq byte1", bus0.meas_data, 8'h0B);
    chk("cs seq valid1", bus0.meas_valid, 1'b1);
    bus0.spi_cs = 1'b1;
    tick(); tick(); tick();
    chk("cs abort valid", bus0.meas_valid, 1'b0);
    chk("cs abort level", bus0.fifo_level, 5'd14);
    word0 = 24'h123456;
    rd_mark = rd_cnt0;
    req_and_wait(0, lat);
    chk("after abort latency", 64'(lat), 64'd3);
    chk("after abort byte0", bus0.meas_data, 8'h56);
    chk("after abort pops", 64'(rd_cnt0 - rd_mark), 64'd1);

    // xfer_done during FETCH discards the fetch but keeps the pop counted
    bus0.xfer_done = 1'b1;
    tick();
    bus0.xfer_done = 1'b0;
    chk("done serve valid", bus0.meas_valid, 1'b0);
    rd_mark = rd_cnt0;
    pulse_req(0);
    bus0.xfer_done = 1'b1;
    tick();
    bus0.xfer_done = 1'b0;
    tick(); tick(); tick(); tick();
    chk("fetch abort valid", bus0.meas_valid, 1'b0);
    chk("fetch abort level", bus0.fifo_level, 5'd12);
    chk("fetch abort pops", 64'(rd_cnt0 - rd_mark), 64'd1);
    chk("fetch abort data", bus0.meas_data, 8'h56);

    // 32-bit MSB-first instance with RD_LAT=3
    bus1.fifo_wr_en = 1'b1;
    tick();
    bus1.fifo_wr_en = 1'b0;
    chk("w32 level", bus1.fifo_level, 5'd1);
    word1 = 32'h11223344;
    req_and_wait(1, lat);
    chk("w32 latency", 64'(lat), 64'd4);
    chk("w32 byte0", bus1.meas_data, exp32[0]);
    for (int k = 1; k < 4; k++) begin
      pulse_req(1);
      chk($sformatf("w32 byte%0d", k), bus1.meas_data, exp32[k]);
      chk($sformatf("w32 valid%0d", k), bus1.meas_valid, 1'b1);
    end
    pulse_req(1);
    chk("w32 end valid", bus1.meas_valid, 1'b0);
    chk("w32 end level", bus1.fifo_level, 5'd0);

    // reset asserted mid-SERVE with req_busy set
    word0 = 24'h778899;
    pulse_req(0);
    pulse_req(0);
    tick();
    chk("pre-rst valid", bus0.meas_valid, 1'b1);
    chk("pre-rst data", bus0.meas_data, 8'h99);
    chk("pre-rst req_busy", bus0.req_busy, 1'b1);
    #2;
    rst_sync = 1'b1;
    #1;
    chk("rst meas_data", bus0.meas_data, 8'h00);
    chk("rst meas_valid", bus0.meas_valid, 1'b0);
    chk("rst fifo_level", bus0.fifo_level, 5'd0);
    chk("rst underflow", bus0.underflow, 1'b0);
    chk("rst req_busy", bus0.req_busy, 1'b0);
    chk("rst fifo_rd_en", bus0.fifo_rd_en, 1'b0);
    rd_mark = rd_cnt0;
    tick(); tick();
    rst_sync = 1'b0;
    tick(); tick(); tick();
    chk("post-rst pops", 64'(rd_cnt0 - rd_mark), 64'd0);
    chk("post-rst valid", bus0.meas_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
